// File: rtl/mem_stage.sv
// mem_stage: data-memory stage between execute and writeback (byte-lane stores, sign/zero-extended loads).
// Optional macro MEM_MISALIGN_CHECK_EN: misaligned lw/sw/lh/lhu/sh complete without a dmem request, flagged via misalign_o.
module mem_stage #(
    parameter  int DATA_W = 32,
    localparam int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] rs2_in,
    input  logic              br_en_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [1:0]        wb_sel,
    input  logic [4:0]        rd_in,
    input  logic              reg_we_in,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [4:0]        rd_o,
    output logic              reg_we_o,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [MASK_W-1:0] dmem_wmask,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic              misalign_o
);

    // state  | meaning
    // EMPTY  | result register free, a new op can be taken
    // ACCESS | dmem request outstanding, waiting for dmem_resp
    // FULL   | completed op held for writeback
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_ACCESS = 2'b01,
        ST_FULL   = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [4:0]          rd_q, rd_d;
    logic                reg_we_q, reg_we_d;
    logic                misalign_q, misalign_d;
    logic                dmem_read_q, dmem_read_d;
    logic                dmem_write_q, dmem_write_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [1:0]          lane_q, lane_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                ld_sel_q, ld_sel_d;

    logic                accept;
    logic                is_load;
    logic                is_store;
    logic                misalign_det;
    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W-1:0]   st_data;
    logic [MASK_W-1:0]   st_mask;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DATA_W-1:0]   ld_fmt;

    assign ready_o  = (state_q == ST_EMPTY) | ((state_q == ST_FULL) & ready_i);
    assign accept   = valid_i & ready_o;
    // Both mem_read and mem_write set is treated as a load.
    assign is_load  = mem_read;
    assign is_store = mem_write & ~mem_read;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_det = (mem_read | mem_write) &
                          ((funct3[1] & (alu_in[1:0] != 2'b00)) |
                           ((funct3[1:0] == 2'b01) & alu_in[0]));
`else
    assign misalign_det = 1'b0;
`endif

    always_comb begin
        sel_data = '0;
        case (wb_sel)
            2'b00:   sel_data = alu_in;
            2'b01:   sel_data = {{(DATA_W-1){1'b0}}, br_en_in};
            2'b10:   sel_data = pc_in + DATA_W'(4);
            default: sel_data = '0;
        endcase
    end

    always_comb begin
        st_mask = 4'hF;
        st_data = rs2_in;
        case (funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << alu_in[1:0];
                st_data = {4{rs2_in[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << {alu_in[1], 1'b0};
                st_data = {2{rs2_in[15:0]}};
            end
            default: begin
                st_mask = 4'hF;
                st_data = rs2_in;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'b0, ld_byte};
            3'b101:  ld_fmt = {16'b0, ld_half};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wb_data_d    = wb_data_q;
        rd_d         = rd_q;
        reg_we_d     = reg_we_q;
        misalign_d   = misalign_q;
        dmem_read_d  = dmem_read_q;
        dmem_write_d = dmem_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        lane_d       = lane_q;
        funct3_d     = funct3_q;
        ld_sel_d     = ld_sel_q;

        case (state_q)
            ST_EMPTY: ;
            ST_ACCESS: begin
                if (dmem_resp) begin
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    state_d      = ST_FULL;
                    if (ld_sel_q) begin
                        wb_data_d = ld_fmt;
                    end
                end
            end
            ST_FULL: begin
                if (ready_i) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // A new op overrides the drain to EMPTY when FULL hands off in the same cycle.
        if (accept) begin
            rd_d       = rd_in;
            wb_data_d  = sel_data;
            funct3_d   = funct3;
            lane_d     = alu_in[1:0];
            ld_sel_d   = is_load & (wb_sel == 2'b11);
            misalign_d = misalign_det;
            reg_we_d   = reg_we_in & ~is_store & ~misalign_det;
            if ((is_load | is_store) & ~misalign_det) begin
                state_d      = ST_ACCESS;
                dmem_read_d  = is_load;
                dmem_write_d = is_store;
                addr_d       = {alu_in[DATA_W-1:2], 2'b00};
                wdata_d      = st_data;
                wmask_d      = st_mask;
            end else begin
                state_d = ST_FULL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            wb_data_q    <= '0;
            rd_q         <= '0;
            reg_we_q     <= 1'b0;
            misalign_q   <= 1'b0;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            lane_q       <= '0;
            funct3_q     <= '0;
            ld_sel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wb_data_q    <= wb_data_d;
            rd_q         <= rd_d;
            reg_we_q     <= reg_we_d;
            misalign_q   <= misalign_d;
            dmem_read_q  <= dmem_read_d;
            dmem_write_q <= dmem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            lane_q       <= lane_d;
            funct3_q     <= funct3_d;
            ld_sel_q     <= ld_sel_d;
        end
    end

    assign valid_o    = (state_q == ST_FULL);
    assign wb_data_o  = wb_data_q;
    assign rd_o       = rd_q;
    assign reg_we_o   = reg_we_q;
    assign misalign_o = misalign_q;
    assign dmem_read  = dmem_read_q;
    assign dmem_write = dmem_write_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: reference model predicts results and dmem requests; a memory responder and
// an output monitor check the DUT independently of the stimulus driver.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o;
    logic [31:0] alu_in, rs2_in, pc_in;
    logic        br_en_in, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [1:0]  wb_sel;
    logic [4:0]  rd_in;
    logic        reg_we_in;
    logic        valid_o, ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_o;
    logic        reg_we_o;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_resp;
    logic        misalign_o;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .alu_in(alu_in), .rs2_in(rs2_in), .br_en_in(br_en_in), .pc_in(pc_in),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .wb_sel(wb_sel),
        .rd_in(rd_in), .reg_we_in(reg_we_in), .valid_o(valid_o), .ready_i(ready_i),
        .wb_data_o(wb_data_o), .rd_o(rd_o), .reg_we_o(reg_we_o),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .misalign_o(misalign_o)
    );

    typedef struct {
        logic [31:0] alu, rs2, pc;
        logic        br, mr, mw;
        logic [2:0]  f3;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
    } op_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we, mis, chk_data;
    } exp_t;

    typedef struct {
        logic [31:0] addr, wdata;
        logic [3:0]  mask;
        logic        wr;
    } req_t;

    exp_t        sb_q[$];
    req_t        rq_q[$];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] bus_mem[int unsigned];

    int n_chk  = 0;
    int n_fail = 0;
    bit resp_en, stray_req, rand_ready, ready_fixed, expect_full_next, expect_req_next;
    int forced_delay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned k);
        return (k * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned k);
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    function automatic logic [31:0] bus_rd(input int unsigned k);
        return bus_mem.exists(k) ? bus_mem[k] : init_word(k);
    endfunction

    function automatic op_t mk(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                               input logic br, input logic mr, input logic mw, input logic [2:0] f3,
                               input logic [1:0] sel, input logic [4:0] rd, input logic we);
        op_t o;
        o.alu = alu; o.rs2 = rs2; o.pc = pc; o.br = br; o.mr = mr; o.mw = mw;
        o.f3 = f3; o.sel = sel; o.rd = rd; o.we = we;
        return o;
    endfunction

    // Reference model: derives result and dmem request from the op and the model memory.
    task automatic model_push(input op_t op);
        exp_t        e;
        req_t        r;
        int unsigned off, k, b, h;
        logic [31:0] word, wd;
        logic [3:0]  mask;
        bit          ld, st, mis;
        ld  = op.mr;
        st  = op.mw && !op.mr;
        off = int'(op.alu % 4);
        k   = op.alu / 4;
        mis = 0;
`ifdef MEM_MISALIGN_CHECK_EN
        if ((ld || st) && ((op.f3[1] && off != 0) || (op.f3[1:0] == 2'b01 && off % 2 == 1))) mis = 1;
`endif
        case (op.sel)
            2'd0:    e.data = op.alu;
            2'd1:    e.data = op.br ? 32'd1 : 32'd0;
            2'd2:    e.data = op.pc + 32'd4;
            default: e.data = 32'd0;
        endcase
        if (ld && !mis) begin
            word = ref_rd(k);
            b = (word >> (8 * off)) % 256;
            h = (word >> (16 * (off / 2))) % 65536;
            if (op.sel == 2'd3) begin
                case (op.f3)
                    3'b000:  e.data = (b >= 128) ? (b + 32'hFFFFFF00) : b;
                    3'b001:  e.data = (h >= 32768) ? (h + 32'hFFFF0000) : h;
                    3'b100:  e.data = b;
                    3'b101:  e.data = h;
                    default: e.data = word;
                endcase
            end
            r.addr = k * 4; r.wdata = 32'd0; r.mask = 4'd0; r.wr = 1'b0;
            rq_q.push_back(r);
        end
        if (st && !mis) begin
            if (op.f3[1:0] == 2'b00) begin
                mask = 4'(1 << off);
                wd   = (op.rs2 % 256) * 32'h01010101;
            end else if (op.f3[1:0] == 2'b01) begin
                mask = 4'(3 << (off / 2 * 2));
                wd   = (op.rs2 % 65536) * 32'h00010001;
            end else begin
                mask = 4'hF;
                wd   = op.rs2;
            end
            word = ref_rd(k);
            for (int i = 0; i < 4; i++) if (mask[i]) word[8*i +: 8] = wd[8*i +: 8];
            ref_mem[k] = word;
            r.addr = k * 4; r.wdata = wd; r.mask = mask; r.wr = 1'b1;
            rq_q.push_back(r);
        end
        e.rd       = op.rd;
        e.we       = op.we && !st && !mis;
        e.mis      = mis;
        e.chk_data = !mis;
        sb_q.push_back(e);
    endtask

    // Called in the phase just after a rising edge; returns in the same phase after the op is taken.
    task automatic issue(input op_t op, output int waited);
        valid_i = 1'b1; alu_in = op.alu; rs2_in = op.rs2; pc_in = op.pc; br_en_in = op.br;
        mem_read = op.mr; mem_write = op.mw; funct3 = op.f3; wb_sel = op.sel;
        rd_in = op.rd; reg_we_in = op.we;
        waited = 0;
        forever begin
            @(negedge clk); #2;
            if (ready_o) begin
                model_push(op);
                if ((op.mr || op.mw) && !sb_q[sb_q.size()-1].mis) expect_req_next = 1;
                else expect_full_next = 1;
                @(posedge clk); #1;
                valid_i = 1'b0;
                return;
            end
            waited++;
            if (waited > 200) begin
                check("issue_timeout", 32'(ready_o), 32'd1);
                @(posedge clk); #1;
                valid_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_data, input logic [4:0] exp_rd);
        int n;
        n = 0;
        @(negedge clk);
        while (!valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(valid_o), 32'd1);
        check({name, "_data"}, wb_data_o, exp_data);
        check({name, "_rd"}, 32'(rd_o), 32'(exp_rd));
        @(posedge clk); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic op_t rand_op();
        op_t o;
        int  kind;
        logic [2:0] ld_f3[5];
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
        kind = int'($urandom_range(0, 2));
        o.rs2 = $urandom; o.br = 1'($urandom); o.rd = 5'($urandom); o.we = 1'($urandom);
        o.pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
        o.alu = 32'h1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        if (kind == 0) begin
            o.alu = $urandom; o.mr = 0; o.mw = 0; o.f3 = 3'($urandom); o.sel = 2'($urandom_range(0, 2));
        end else if (kind == 1) begin
            o.mr = 1; o.mw = ($urandom_range(0, 3) == 0); o.f3 = ld_f3[$urandom_range(0, 4)]; o.sel = 2'd3;
        end else begin
            o.mr = 0; o.mw = 1; o.f3 = 3'($urandom_range(0, 2)); o.sel = 2'($urandom_range(0, 2));
        end
        return o;
    endfunction

    initial begin : ready_drv
        ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
        end
    end

    initial begin : responder
        int          wait_cnt;
        bit          seen;
        req_t        cur;
        logic [31:0] s_addr, s_wdata, w;
        logic [3:0]  s_mask;
        logic        s_rd, s_wr;
        int unsigned k;
        dmem_resp = 1'b0; dmem_rdata = 32'd0; seen = 0; wait_cnt = 0;
        forever begin
            @(posedge clk); #1;
            dmem_resp  = 1'b0;
            dmem_rdata = $urandom;
            if (stray_req) begin
                dmem_resp = 1'b1;
                stray_req = 0;
            end else if (!rst && (dmem_read || dmem_write)) begin
                if (!seen) begin
                    seen = 1;
                    s_addr = dmem_addr; s_wdata = dmem_wdata; s_mask = dmem_wmask;
                    s_rd = dmem_read; s_wr = dmem_write;
                    wait_cnt = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
                    if (rq_q.size() == 0) begin
                        check("unexpected_req", 32'(dmem_read | dmem_write), 32'd0);
                    end else begin
                        cur = rq_q.pop_front();
                        check("req_addr", dmem_addr, cur.addr);
                        check("req_write", 32'(dmem_write), 32'(cur.wr));
                        check("req_read", 32'(dmem_read), 32'(!cur.wr));
                        if (cur.wr) begin
                            check("req_mask", 32'(dmem_wmask), 32'(cur.mask));
                            check("req_wdata", dmem_wdata, cur.wdata);
                        end
                    end
                end else begin
                    check("hold_addr", dmem_addr, s_addr);
                    check("hold_wdata", dmem_wdata, s_wdata);
                    check("hold_mask", 32'(dmem_wmask), 32'(s_mask));
                    check("hold_read", 32'(dmem_read), 32'(s_rd));
                    check("hold_write", 32'(dmem_write), 32'(s_wr));
                end
                if (resp_en && wait_cnt == 0) begin
                    dmem_resp = 1'b1;
                    k = {2'b00, dmem_addr[31:2]};
                    if (dmem_write && !dmem_read) begin
                        w = bus_rd(k);
                        for (int i = 0; i < 4; i++) if (dmem_wmask[i]) w[8*i +: 8] = dmem_wdata[8*i +: 8];
                        bus_mem[k] = w;
                    end else begin
                        dmem_rdata = bus_rd(k);
                    end
                end else if (wait_cnt > 0) begin
                    wait_cnt--;
                end
            end else begin
                seen = 0;
            end
        end
    end

    initial begin : monitor
        exp_t        e;
        bit          prev_stall;
        logic [31:0] pd;
        logic [4:0]  prd;
        logic        pwe, pmis;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                continue;
            end
            if (expect_full_next) begin
                check("latency_full", 32'(valid_o), 32'd1);
                expect_full_next = 0;
            end
            if (expect_req_next) begin
                check("latency_req", 32'(dmem_read | dmem_write), 32'd1);
                check("access_not_valid", 32'(valid_o), 32'd0);
                expect_req_next = 0;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(valid_o), 32'd1);
                check("stall_data", wb_data_o, pd);
                check("stall_rd", 32'(rd_o), 32'(prd));
                check("stall_we", 32'(reg_we_o), 32'(pwe));
                check("stall_mis", 32'(misalign_o), 32'(pmis));
            end
            if (!valid_o) check("ready_not_full", 32'(ready_o), 32'(sb_q.size() == 0));
            else          check("ready_full", 32'(ready_o), 32'(ready_i));
            if (valid_o) begin
                if (sb_q.size() == 0) begin
                    check("valid_without_op", 32'(valid_o), 32'd0);
                end else begin
                    e = sb_q[0];
                    if (e.chk_data) check("wb_data", wb_data_o, e.data);
                    check("rd", 32'(rd_o), 32'(e.rd));
                    check("reg_we", 32'(reg_we_o), 32'(e.we));
                    check("misalign", 32'(misalign_o), 32'(e.mis));
                    if (ready_i) void'(sb_q.pop_front());
                end
            end
            prev_stall = valid_o && !ready_i;
            pd = wb_data_o; prd = rd_o; pwe = reg_we_o; pmis = misalign_o;
        end
    end

    initial begin : main
        int w;
        int n;
        rst = 1'b1; valid_i = 0; alu_in = 0; rs2_in = 0; br_en_in = 0; pc_in = 0;
        mem_read = 0; mem_write = 0; funct3 = 0; wb_sel = 0; rd_in = 0; reg_we_in = 0;
        resp_en = 1; stray_req = 0; rand_ready = 0; ready_fixed = 1; forced_delay = -1;
        expect_full_next = 0; expect_req_next = 0;
        #12;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_we", 32'(reg_we_o), 32'd0);
        check("rst_dread", 32'(dmem_read), 32'd0);
        check("rst_dwrite", 32'(dmem_write), 32'd0);
        check("rst_mis", 32'(misalign_o), 32'd0);
        check("rst_data", wb_data_o, 32'd0);
        check("rst_rd", 32'(rd_o), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_mask", 32'(dmem_wmask), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles(1);

        issue(mk(32'h1234, 0, 32'h100, 0, 0, 0, 3'b000, 2'b00, 5'd5, 1), w);
        wait_valid("add", 32'h1234, 5'd5);

        ref_mem[32'h400] = 32'h80FFFFFF;
        bus_mem[32'h400] = 32'h80FFFFFF;
        forced_delay = 3;
        issue(mk(32'h1003, 0, 0, 0, 1, 0, 3'b000, 2'b11, 5'd6, 1), w);
        wait_valid("lb", 32'hFFFFFF80, 5'd6);
        issue(mk(32'h1003, 0, 0, 0, 1, 0, 3'b100, 2'b11, 5'd7, 1), w);
        wait_valid("lbu", 32'h00000080, 5'd7);

        issue(mk(32'h2002, 32'hABCD1234, 0, 0, 0, 1, 3'b001, 2'b00, 5'd8, 1), w);
        check("sh_write", 32'(dmem_write), 32'd1);
        check("sh_mask", 32'(dmem_wmask), 32'hC);
        check("sh_wdata", dmem_wdata, 32'h12341234);
        wait_valid("sh", 32'h2002, 5'd8);
        forced_delay = -1;

        issue(mk(32'h0, 0, 32'hFFFFFFFC, 0, 0, 0, 3'b000, 2'b10, 5'd9, 1), w);
        wait_valid("pc_wrap", 32'h0, 5'd9);

        ready_fixed = 0;
        cycles(1);
        issue(mk(32'hCAFE0001, 0, 0, 1, 0, 0, 3'b000, 2'b01, 5'd10, 1), w);
        cycles(4);
        check("stall_ready_o", 32'(ready_o), 32'd0);
        ready_fixed = 1;
        cycles(1);
        for (int i = 0; i < 6; i++) begin
            issue(mk(32'h100 + 32'(i), 0, 0, 0, 0, 0, 3'b000, 2'b00, 5'(11 + i), 1), w);
            check("no_bubble", 32'(w), 32'd0);
        end
        cycles(2);

`ifdef MEM_MISALIGN_CHECK_EN
        issue(mk(32'h1001, 0, 0, 0, 1, 0, 3'b010, 2'b11, 5'd20, 1), w);
        check("mis_no_read", 32'(dmem_read), 32'd0);
        check("mis_flag", 32'(misalign_o), 32'd1);
        check("mis_we", 32'(reg_we_o), 32'd0);
`else
        issue(mk(32'h1001, 0, 0, 0, 1, 0, 3'b010, 2'b11, 5'd20, 1), w);
        wait_valid("lw_unaligned", 32'h80FFFFFF, 5'd20);
        check("mis_tied", 32'(misalign_o), 32'd0);
`endif
        cycles(2);

        resp_en = 0;
        issue(mk(32'h1010, 0, 0, 0, 1, 0, 3'b010, 2'b11, 5'd3, 1), w);
        @(negedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_drops_read", 32'(dmem_read), 32'd0);
        check("rst_mid_valid", 32'(valid_o), 32'd0);
        sb_q.delete();
        rq_q.delete();
        expect_full_next = 0;
        expect_req_next  = 0;
        @(negedge clk);
        rst = 1'b0;
        resp_en = 1;
        stray_req = 1;
        repeat (4) begin
            @(negedge clk);
            check("stray_valid", 32'(valid_o), 32'd0);
            check("stray_read", 32'(dmem_read), 32'd0);
        end
        cycles(1);

        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            issue(rand_op(), w);
            if ($urandom_range(0, 3) == 0) cycles(int'($urandom_range(1, 2)));
        end

        rand_ready = 0;
        ready_fixed = 1;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            cycles(1);
            n++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
